issue_queue3: RTL and testbench

- Reservation-station stage directly upstream of the ALU/FPU execute unit.
- Holds up to DEPTH decoded instructions whose source operands may still be pending.
- Snoops the ALU and FPU write-back buses to capture missing operands, and issues the oldest ready entry each cycle.
- Issue outputs are registered. Execute is combinational, so a nop (ope=0, ctrl=0) is driven on any cycle with no issue.

---
 rtl/issue_queue3_pkg.sv | 47 ++++
 rtl/issue_queue3_rs_wakeup.sv | 34 +++
 rtl/issue_queue3.sv | 191 +++++++++++++++++++
 tb/tb_issue_queue3.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue3_pkg.sv
// Shared definitions for the issue_queue3 reservation station.
// Holds the nop encoding, tag/value widths, the stored entry layout
// (as a packed struct plus matching LSB bit offsets so decode and
// execute can slice a flattened entry), and the broadcast tag match helper.
package issue_queue3_pkg;

    localparam int TAG_W = 6;
    localparam int VAL_W = 32;

    localparam logic [5:0] OPE_NOP  = 6'b000000;
    localparam logic [3:0] CTRL_NOP = 4'b0000;

    typedef struct packed {
        logic             valid;
        logic [5:0]       ope;
        logic [3:0]       ctrl;
        logic [5:0]       dd;
        logic [15:0]      imm;
        logic             ds_rdy;
        logic [TAG_W-1:0] ds_tag;
        logic [VAL_W-1:0] ds_val;
        logic             dt_rdy;
        logic [TAG_W-1:0] dt_tag;
        logic [VAL_W-1:0] dt_val;
    } rs_entry_t;

    // LSB offsets of each field inside a flattened rs_entry_t.
    localparam int OFF_DT_VAL = 0;
    localparam int OFF_DT_TAG = OFF_DT_VAL + VAL_W;
    localparam int OFF_DT_RDY = OFF_DT_TAG + TAG_W;
    localparam int OFF_DS_VAL = OFF_DT_RDY + 1;
    localparam int OFF_DS_TAG = OFF_DS_VAL + VAL_W;
    localparam int OFF_DS_RDY = OFF_DS_TAG + TAG_W;
    localparam int OFF_IMM    = OFF_DS_RDY + 1;
    localparam int OFF_DD     = OFF_IMM + 16;
    localparam int OFF_CTRL   = OFF_DD + 6;
    localparam int OFF_OPE    = OFF_CTRL + 4;
    localparam int OFF_VALID  = OFF_OPE + 6;
    localparam int ENTRY_W    = OFF_VALID + 1;

    // Address 0 means "no write-back", so it can never wake an operand.
    function automatic logic tag_hit(input logic [TAG_W-1:0] addr,
                                     input logic [TAG_W-1:0] tag);
        return (addr != '0) && (addr == tag);
    endfunction

endpackage

// File: rtl/issue_queue3_rs_wakeup.sv
// rs_wakeup: operand wakeup for one source operand.
// Ports: rdy/tag/val   - operand state before this cycle's broadcasts
//        alu_*/fpu_*   - write-back buses (addr 0 = no write)
//        rdy_next/val_next - operand state after snooping both buses
module rs_wakeup
    import issue_queue3_pkg::*;
(
    input  logic             rdy,
    input  logic [TAG_W-1:0] tag,
    input  logic [VAL_W-1:0] val,
    input  logic [TAG_W-1:0] alu_addr,
    input  logic [VAL_W-1:0] alu_val,
    input  logic [TAG_W-1:0] fpu_addr,
    input  logic [VAL_W-1:0] fpu_val,
    output logic             rdy_next,
    output logic [VAL_W-1:0] val_next
);

    always_comb begin
        rdy_next = rdy;
        val_next = val;
        if (!rdy) begin
            // ALU checked first so it wins if both buses carry the tag.
            if (tag_hit(alu_addr, tag)) begin
                rdy_next = 1'b1;
                val_next = alu_val;
            end else if (tag_hit(fpu_addr, tag)) begin
                rdy_next = 1'b1;
                val_next = fpu_val;
            end
        end
    end

endmodule

// File: rtl/issue_queue3.sv
// issue_queue3: age-ordered reservation station feeding the ALU/FPU.
// Ports: clk, rstn (async, active-high), flush (sync kill)
//        in_*        - dispatch request with operand ready/tag/value
//        in_ready    - space available (count < DEPTH)
//        alu_*/fpu_* - write-back buses snooped for operand wakeup
//        unit_busy   - any bit set stalls issue
//        ope..dt_val - registered issue bundle (nop when nothing issues)
//        count       - occupied entries
module issue_queue3
    import issue_queue3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_ope,
    input  logic [3:0]       in_ctrl,
    input  logic [5:0]       in_dd,
    input  logic [15:0]      in_imm,
    input  logic             in_ds_rdy,
    input  logic [5:0]       in_ds_tag,
    input  logic [31:0]      in_ds_val,
    input  logic             in_dt_rdy,
    input  logic [5:0]       in_dt_tag,
    input  logic [31:0]      in_dt_val,
    input  logic [5:0]       alu_addr,
    input  logic [31:0]      alu_dd_val,
    input  logic [5:0]       fpu_addr,
    input  logic [31:0]      fpu_dd_val,
    input  logic [6:0]       unit_busy,
    output logic [5:0]       ope,
    output logic [3:0]       ctrl,
    output logic [5:0]       dd,
    output logic [15:0]      imm,
    output logic [31:0]      ds_val,
    output logic [31:0]      dt_val,
    output logic [IDX_W:0]   count
);

    rs_entry_t        ent_q  [DEPTH];
    rs_entry_t        ent_d  [DEPTH];
    rs_entry_t        ent_wk [DEPTH];
    logic             wk_ds_rdy [DEPTH];
    logic [VAL_W-1:0] wk_ds_val [DEPTH];
    logic             wk_dt_rdy [DEPTH];
    logic [VAL_W-1:0] wk_dt_val [DEPTH];

    logic [IDX_W:0]   count_q, count_d;
    logic [5:0]       ope_q, ope_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [5:0]       dd_q, dd_d;
    logic [15:0]      imm_q, imm_d;
    logic [31:0]      ds_val_q, ds_val_d;
    logic [31:0]      dt_val_q, dt_val_d;

    rs_entry_t        disp_ent;
    logic             disp_ds_rdy, disp_dt_rdy;
    logic [VAL_W-1:0] disp_ds_val, disp_dt_val;
    logic             found, issue_en, disp_en;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   slot;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wk
        rs_wakeup u_wk_ds (
            .rdy(ent_q[g].ds_rdy), .tag(ent_q[g].ds_tag), .val(ent_q[g].ds_val),
            .alu_addr(alu_addr), .alu_val(alu_dd_val),
            .fpu_addr(fpu_addr), .fpu_val(fpu_dd_val),
            .rdy_next(wk_ds_rdy[g]), .val_next(wk_ds_val[g])
        );
        rs_wakeup u_wk_dt (
            .rdy(ent_q[g].dt_rdy), .tag(ent_q[g].dt_tag), .val(ent_q[g].dt_val),
            .alu_addr(alu_addr), .alu_val(alu_dd_val),
            .fpu_addr(fpu_addr), .fpu_val(fpu_dd_val),
            .rdy_next(wk_dt_rdy[g]), .val_next(wk_dt_val[g])
        );
    end

    rs_wakeup u_disp_ds (
        .rdy(in_ds_rdy), .tag(in_ds_tag), .val(in_ds_val),
        .alu_addr(alu_addr), .alu_val(alu_dd_val),
        .fpu_addr(fpu_addr), .fpu_val(fpu_dd_val),
        .rdy_next(disp_ds_rdy), .val_next(disp_ds_val)
    );
    rs_wakeup u_disp_dt (
        .rdy(in_dt_rdy), .tag(in_dt_tag), .val(in_dt_val),
        .alu_addr(alu_addr), .alu_val(alu_dd_val),
        .fpu_addr(fpu_addr), .fpu_val(fpu_dd_val),
        .rdy_next(disp_dt_rdy), .val_next(disp_dt_val)
    );

    // Full blocks dispatch even when an issue frees a slot this cycle.
    assign in_ready = (count_q < (IDX_W+1)'(DEPTH));

    always_comb begin
        disp_ent = '{valid: 1'b1, ope: in_ope, ctrl: in_ctrl, dd: in_dd, imm: in_imm,
                     ds_rdy: disp_ds_rdy, ds_tag: in_ds_tag, ds_val: disp_ds_val,
                     dt_rdy: disp_dt_rdy, dt_tag: in_dt_tag, dt_val: disp_dt_val};

        // Wakeup results double as the bypass for this cycle's selection.
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_wk[i]        = ent_q[i];
            ent_wk[i].ds_rdy = wk_ds_rdy[i];
            ent_wk[i].ds_val = wk_ds_val[i];
            ent_wk[i].dt_rdy = wk_dt_rdy[i];
            ent_wk[i].dt_val = wk_dt_val[i];
            if (!found && ent_q[i].valid && wk_ds_rdy[i] && wk_dt_rdy[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end

        issue_en = found && (unit_busy == '0) && !flush;
        disp_en  = in_valid && in_ready && !flush;
        slot     = issue_en ? count_q - 1'b1 : count_q;

        // Compact: entries above the issued one move down by one.
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_wk[i];
        end
        if (issue_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel)) ent_d[i] = ent_wk[i+1];
            end
            ent_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_en && (i == int'(slot))) ent_d[i] = disp_ent;
        end

        count_d = count_q;
        if (disp_en && !issue_en)      count_d = count_q + 1'b1;
        else if (!disp_en && issue_en) count_d = count_q - 1'b1;

        ope_d    = OPE_NOP;
        ctrl_d   = CTRL_NOP;
        dd_d     = '0;
        imm_d    = '0;
        ds_val_d = '0;
        dt_val_d = '0;
        if (issue_en) begin
            ope_d    = ent_wk[sel].ope;
            ctrl_d   = ent_wk[sel].ctrl;
            dd_d     = ent_wk[sel].dd;
            imm_d    = ent_wk[sel].imm;
            ds_val_d = ent_wk[sel].ds_val;
            dt_val_d = ent_wk[sel].dt_val;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q  <= '0;
            ope_q    <= '0;
            ctrl_q   <= '0;
            dd_q     <= '0;
            imm_q    <= '0;
            ds_val_q <= '0;
            dt_val_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q  <= count_d;
            ope_q    <= ope_d;
            ctrl_q   <= ctrl_d;
            dd_q     <= dd_d;
            imm_q    <= imm_d;
            ds_val_q <= ds_val_d;
            dt_val_q <= dt_val_d;
        end
    end

    assign ope    = ope_q;
    assign ctrl   = ctrl_q;
    assign dd     = dd_q;
    assign imm    = imm_q;
    assign ds_val = ds_val_q;
    assign dt_val = dt_val_q;
    assign count  = count_q;

endmodule

// File: tb/tb_issue_queue3.sv
module tb_issue_queue3;

    logic        clk, rstn, flush, in_valid, in_ready;
    logic [5:0]  in_ope, in_dd, in_ds_tag, in_dt_tag, alu_addr, fpu_addr;
    logic [3:0]  in_ctrl;
    logic [15:0] in_imm;
    logic        in_ds_rdy, in_dt_rdy;
    logic [31:0] in_ds_val, in_dt_val, alu_dd_val, fpu_dd_val;
    logic [6:0]  unit_busy;
    logic [5:0]  ope, dd;
    logic [3:0]  ctrl;
    logic [15:0] imm;
    logic [31:0] ds_val, dt_val;
    logic [2:0]  count;

    issue_queue3 #(.DEPTH(4), .IDX_W(2)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ope(in_ope), .in_ctrl(in_ctrl), .in_dd(in_dd), .in_imm(in_imm),
        .in_ds_rdy(in_ds_rdy), .in_ds_tag(in_ds_tag), .in_ds_val(in_ds_val),
        .in_dt_rdy(in_dt_rdy), .in_dt_tag(in_dt_tag), .in_dt_val(in_dt_val),
        .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
        .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
        .unit_busy(unit_busy),
        .ope(ope), .ctrl(ctrl), .dd(dd), .imm(imm),
        .ds_val(ds_val), .dt_val(dt_val), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [95:0] sb [$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] o, input logic [3:0] c, input logic [5:0] d,
                        input logic [15:0] im, input logic [31:0] sv, input logic [31:0] tv);
        sb.push_back({o, c, d, im, sv, tv});
    endtask

    task automatic check_issue(input string tag);
        logic [95:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            chk(tag, {ope, ctrl, dd, imm, ds_val, dt_val}, exp);
        end
    endtask

    task automatic check_nop(input string tag);
        chk(tag, {ope, ctrl, dd, imm, ds_val, dt_val}, 0);
    endtask

    task automatic set_in(input logic [5:0] o, input logic [3:0] c, input logic [5:0] d,
                          input logic [15:0] im,
                          input logic sr, input logic [5:0] st, input logic [31:0] sv,
                          input logic tr, input logic [5:0] tt, input logic [31:0] tv);
        in_ope = o; in_ctrl = c; in_dd = d; in_imm = im;
        in_ds_rdy = sr; in_ds_tag = st; in_ds_val = sv;
        in_dt_rdy = tr; in_dt_tag = tt; in_dt_val = tv;
    endtask

    task automatic disp(input logic [5:0] o, input logic [3:0] c, input logic [5:0] d,
                        input logic [15:0] im,
                        input logic sr, input logic [5:0] st, input logic [31:0] sv,
                        input logic tr, input logic [5:0] tt, input logic [31:0] tv);
        set_in(o, c, d, im, sr, st, sv, tr, tt, tv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; unit_busy = '0;
        alu_addr = '0; alu_dd_val = '0; fpu_addr = '0; fpu_dd_val = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rstn = 1'b1;
        #1;
        check_nop("reset_nop");
        chk("reset_count", count, 0);
        tick();
        rstn = 1'b0;
        chk("reset_in_ready", in_ready, 1);

        // ready dispatch
        disp(6'b001100, 4'h2, 6'd10, 16'd3, 1, 0, 32'd5, 1, 0, 32'd0);
        check_nop("ready_disp_cycle_nop");
        chk("ready_disp_count1", count, 1);
        push(6'b001100, 4'h2, 6'd10, 16'd3, 32'd5, 32'd0);
        tick();
        check_issue("ready_issue");
        chk("ready_count0", count, 0);
        tick();
        check_nop("ready_after_nop");

        // wakeup with bypass
        disp(6'd2, 0, 6'd4, 0, 0, 6'd7, 0, 1, 0, 32'h11);
        for (int i = 0; i < 3; i++) begin
            check_nop("wait_nop");
            chk("wait_count1", count, 1);
            tick();
        end
        alu_addr = 6'd7; alu_dd_val = 32'h1234;
        push(6'd2, 0, 6'd4, 0, 32'h1234, 32'h11);
        tick();
        alu_addr = '0;
        check_issue("bypass_issue");
        chk("bypass_count0", count, 0);

        // age order, full queue
        unit_busy = 7'b0000001;
        disp(6'd3, 0, 6'd1, 0, 0, 6'd12, 0, 1, 0, 32'h30);
        disp(6'd4, 0, 6'd2, 0, 1, 0, 32'h41, 0, 6'd13, 0);
        disp(6'd5, 0, 6'd3, 0, 1, 0, 32'h50, 1, 0, 32'h51);
        disp(6'd6, 0, 6'd4, 0, 1, 0, 32'h60, 1, 0, 32'h61);
        chk("full_count4", count, 4);
        chk("full_in_ready0", in_ready, 0);
        check_nop("full_stalled_nop");
        unit_busy = '0;
        set_in(6'd7, 0, 6'd5, 0, 1, 0, 32'h70, 1, 0, 32'h71);
        in_valid = 1'b1;
        chk("full_in_ready0_during_issue", in_ready, 0);
        push(6'd5, 0, 6'd3, 0, 32'h50, 32'h51);
        tick();
        in_valid = 1'b0;
        check_issue("age_e2_first");
        chk("age_count3", count, 3);
        fpu_addr = 6'd12; fpu_dd_val = 32'hF00D;
        push(6'd3, 0, 6'd1, 0, 32'hF00D, 32'h30);
        tick();
        fpu_addr = '0;
        check_issue("age_e0_before_e3");
        chk("age_count2", count, 2);
        push(6'd6, 0, 6'd4, 0, 32'h60, 32'h61);
        tick();
        check_issue("age_e3");
        chk("age_count1", count, 1);
        alu_addr = 6'd13; alu_dd_val = 32'h55;
        push(6'd4, 0, 6'd2, 0, 32'h41, 32'h55);
        tick();
        alu_addr = '0;
        check_issue("age_e1_dt_wake");
        chk("age_count0", count, 0);
        tick();
        check_nop("full_drop_nop");

        // tag 0 never matches; ALU wins over FPU
        alu_addr = 6'd0; alu_dd_val = 32'hDEAD;
        disp(6'd8, 0, 6'd5, 0, 0, 6'd0, 0, 1, 0, 0);
        tick();
        check_nop("tag0_nop");
        chk("tag0_count1", count, 1);
        disp(6'd9, 0, 6'd6, 0, 0, 6'd9, 0, 1, 0, 32'h99);
        check_nop("prio_wait_nop");
        chk("prio_count2", count, 2);
        alu_addr = 6'd9; alu_dd_val = 32'hAAAA_AAAA;
        fpu_addr = 6'd9; fpu_dd_val = 32'hBBBB_BBBB;
        push(6'd9, 0, 6'd6, 0, 32'hAAAA_AAAA, 32'h99);
        tick();
        alu_addr = '0; fpu_addr = '0;
        check_issue("prio_alu_wins");
        chk("prio_count1", count, 1);

        // wakeup in the dispatch cycle
        alu_addr = 6'd20; alu_dd_val = 32'h77;
        disp(6'd14, 0, 6'd7, 0, 0, 6'd20, 0, 1, 0, 32'h1);
        alu_addr = '0;
        check_nop("dispwk_own_cycle_nop");
        chk("dispwk_count2", count, 2);
        push(6'd14, 0, 6'd7, 0, 32'h77, 32'h1);
        tick();
        check_issue("dispwk_issue");
        chk("dispwk_count1", count, 1);

        // stall
        unit_busy = 7'b0000001;
        disp(6'd10, 4'h5, 6'd8, 16'h10, 1, 0, 32'hA, 1, 0, 32'hB);
        check_nop("stall_nop1");
        tick();
        check_nop("stall_nop2");
        chk("stall_count2", count, 2);
        unit_busy = '0;
        push(6'd10, 4'h5, 6'd8, 16'h10, 32'hA, 32'hB);
        tick();
        check_issue("stall_release_issue");
        chk("stall_count1", count, 1);

        // flush with 3 entries, eligible issue, and a same-cycle dispatch
        disp(6'd15, 0, 6'd9, 0, 0, 6'd30, 0, 1, 0, 0);
        disp(6'd12, 0, 6'd9, 0, 1, 0, 32'hC, 1, 0, 32'hD);
        chk("flush_pre_count3", count, 3);
        flush = 1'b1;
        set_in(6'd11, 0, 6'd9, 0, 1, 0, 32'hE, 1, 0, 32'hF);
        in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_nop("flush_nop");
        chk("flush_count0", count, 0);
        tick();
        check_nop("flush_dispatch_dropped");
        chk("flush_count_still0", count, 0);

        // async reset mid-cycle
        disp(6'd13, 0, 6'd9, 0, 1, 0, 32'h13, 1, 0, 32'h14);
        push(6'd13, 0, 6'd9, 0, 32'h13, 32'h14);
        disp(6'd16, 0, 6'd10, 0, 1, 0, 32'h16, 1, 0, 32'h17);
        check_issue("pre_reset_issue");
        chk("pre_reset_count1", count, 1);
        #2 rstn = 1'b1;
        #1;
        check_nop("async_reset_nop");
        chk("async_reset_count0", count, 0);
        rstn = 1'b0;
        tick();
        check_nop("post_reset_nop");
        chk("post_reset_count0", count, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
